mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master memory bus arbiter and address decoder between the core's requesters (e.g. instruction fetch and data/load-store, or core and a debug/DMA master) and the bram, uart and timer slaves. It grants the bus round-robin and carries one outstanding transaction at a time. Each transaction is decoded to exactly one slave and sequenced through a valid-pulse/ready-pulse handshake. Unmapped addresses and unresponsive slaves return an error response instead of hanging the bus.

## Interface
Parameters:
- UART_ADDR, 32'h1000_0000, uart data register; word match on addr[31:2]
- TIMER_BASE, 32'h0200_0000, timer region base (mtime/mtimecmp live here)
- TIMER_MASK, 32'hFFFF_0000, timer hit when (addr & TIMER_MASK) == TIMER_BASE
- BRAM_SIZE, 32'h0010_0000, bram hit when addr < BRAM_SIZE (base 0)
- TIMEOUT, 1024, max cycles in WAIT before error; range 2..65535

Ports (m0/m1 and slave groups are identical per instance):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- m0_valid / m1_valid  in  1  request, held with its fields until that master's ready
- m0_instr / m1_instr  in  1  instruction-fetch qualifier, passed through
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte strobes; 0 = read
- m0_rdata / m1_rdata  out  32  read data, valid while ready=1
- m0_ready / m1_ready  out  1  one-cycle response pulse
- m0_error / m1_error  out  1  qualifies ready: unmapped or timed out
- s_instr, s_addr, s_wdata, s_wstrb  out  1/32/32/4  registered request fields, shared by all slaves
- bram_valid / uart_valid / timer_valid  out  1  one-cycle request pulse to selected slave
- bram_rdata / uart_rdata / timer_rdata  in  32  slave read data
- bram_ready / uart_ready / timer_ready  in  1  slave response pulse

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE, no mN_valid: stay.
- IDLE, one valid: grant that master.
- IDLE, both valid: grant the master not granted last; `last` resets to 1, so m0 wins the first tie.
- On grant:
  - latch grant index, instr/addr/wdata/wstrb into s_*;
  - decode sel ∈ {BRAM, UART, TIMER, NONE} in priority UART > TIMER > BRAM;
  - update `last`; go REQ.
- REQ, sel≠NONE: assert that slave's valid for this cycle only; clear timeout counter; go WAIT.
- REQ, sel=NONE: set err=1, rdata reg=0; go RESP. No slave valid is asserted.
- WAIT:
  - s_* held; all slave valids 0.
  - Only the selected slave's ready is observed; ready/rdata from other slaves are ignored.
  - Selected ready=1: capture its rdata; err=0; go RESP.
  - Otherwise increment counter. When counter reaches TIMEOUT-1 without ready: err=1, rdata=0, go RESP.
  - Ready in the timeout cycle wins (normal response).
- RESP: granted master gets ready=1, rdata and error for one cycle; the other master's outputs stay 0; go IDLE.
- Masters drop valid or present a new request the cycle after ready. The arbiter re-samples in IDLE.
- Writes (wstrb≠0) follow the same path. rdata on writes is whatever the slave returned.
- A late ready from a timed-out slave, arriving in IDLE or in a later transaction to another slave, is ignored.

## Timing
- Reset (rst=0, asynchronous), takes effect immediately:
  - state=IDLE, last=1, counter=0;
  - all mN_ready/mN_error/mN_rdata=0, all slave valids=0, s_*=0.
  - Assertion mid-transaction abandons it with no response.
- Mapped access: valid sampled in IDLE at cycle 0; slave valid in cycle 1; slave ready at cycle 1+k (k≥1); master ready at cycle 2+k. Minimum 3 cycles (bram k=1).
- Unmapped access: master ready+error in cycle 2.
- Timeout: master ready+error exactly TIMEOUT+1 cycles after the REQ cycle.
- Back-to-back: a new grant is possible in the cycle after RESP, so sustained throughput is one transaction per 4 cycles at k=1.
- Both masters continuously requesting alternate strictly m0, m1, m0, …

## Test plan
- Single m0 read at 0x100, bram ready one cycle after valid, rdata 0xDEADBEEF -> bram_valid pulse cycle 1, m0_ready=1 with rdata 0xDEADBEEF at cycle 3, error=0, m1 outputs 0.
- m0 and m1 assert valid in the same cycle after reset (m0 write 0x1000_0000 wstrb 4'h1, m1 read 0x200) -> m0 granted first (uart_valid), then m1 (bram_valid); next simultaneous pair is granted to m0 again only after m1.
- m1 read 0x0200_BFF8 -> timer_valid only, s_addr=0x0200_BFF8, timer rdata returned to m1.
- m0 read 0x8000_0000 (unmapped) -> no slave valid, m0_ready=1, m0_error=1, rdata=0 at cycle 2.
- TIMEOUT=8, bram never responds -> m0_ready+error 9 cycles after REQ. A later stray bram_ready during an m1 uart transaction is ignored.
- rst pulsed low while in WAIT -> all outputs 0 immediately, no ready issued, next request served normally with m0 tie-priority.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin bus arbiter and bram/uart/timer decoder
module mem_arbiter #(
  parameter logic [31:0] UART_ADDR  = 32'h1000_0000,
  parameter logic [31:0] TIMER_BASE = 32'h0200_0000,
  parameter logic [31:0] TIMER_MASK = 32'hFFFF_0000,
  parameter logic [31:0] BRAM_SIZE  = 32'h0010_0000,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_error,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_error,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        bram_valid,
  output logic        uart_valid,
  output logic        timer_valid,
  input  logic [31:0] bram_rdata,
  input  logic [31:0] uart_rdata,
  input  logic [31:0] timer_rdata,
  input  logic        bram_ready,
  input  logic        uart_ready,
  input  logic        timer_ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_BRAM, SEL_UART, SEL_TIMER} sel_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  sel_t        sel_q, sel_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  // UART wins over TIMER wins over BRAM when regions overlap.
  function automatic sel_t decode(input logic [31:0] a);
    if (a[31:2] == UART_ADDR[31:2])             return SEL_UART;
    else if ((a & TIMER_MASK) == TIMER_BASE)     return SEL_TIMER;
    else if (a < BRAM_SIZE)                      return SEL_BRAM;
    else                                         return SEL_NONE;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_NONE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      instr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    // Only the selected slave's handshake is visible; strays from others are dropped.
    case (sel_q)
      SEL_BRAM:  begin sel_ready = bram_ready;  sel_rdata = bram_rdata;  end
      SEL_UART:  begin sel_ready = uart_ready;  sel_rdata = uart_rdata;  end
      SEL_TIMER: begin sel_ready = timer_ready; sel_rdata = timer_rdata; end
      default:   begin sel_ready = 1'b0;        sel_rdata = '0;          end
    endcase

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          gnt_d   = (m0_valid && m1_valid) ? ~last_q : m1_valid;
          last_d  = gnt_d;
          instr_d = gnt_d ? m1_instr : m0_instr;
          addr_d  = gnt_d ? m1_addr  : m0_addr;
          wdata_d = gnt_d ? m1_wdata : m0_wdata;
          wstrb_d = gnt_d ? m1_wstrb : m0_wstrb;
          sel_d   = decode(addr_d);
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = '0;
        if (sel_q == SEL_NONE) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sel_ready) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bram_valid  = 1'b0;
    uart_valid  = 1'b0;
    timer_valid = 1'b0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    if (state_q == REQ) begin
      bram_valid  = (sel_q == SEL_BRAM);
      uart_valid  = (sel_q == SEL_UART);
      timer_valid = (sel_q == SEL_TIMER);
    end
    if (state_q == RESP) begin
      m0_ready = ~gnt_q;
      m1_ready = gnt_q;
    end
    m0_error = m0_ready & err_q;
    m1_error = m1_ready & err_q;
    m0_rdata = m0_ready ? rdata_q : '0;
    m1_rdata = m1_ready ? rdata_q : '0;
  end

  assign s_instr = instr_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk, rst;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m0_error, m1_ready, m1_error;
  logic        s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        bram_valid, uart_valid, timer_valid;
  logic [31:0] bram_rdata, uart_rdata, timer_rdata;
  logic        bram_ready, uart_ready, timer_ready;
  int          checks = 0;
  int          failures = 0;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_error(m1_error),
    .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .bram_valid(bram_valid), .uart_valid(uart_valid), .timer_valid(timer_valid),
    .bram_rdata(bram_rdata), .uart_rdata(uart_rdata), .timer_rdata(timer_rdata),
    .bram_ready(bram_ready), .uart_ready(uart_ready), .timer_ready(timer_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    bram_rdata = 0; uart_rdata = 0; timer_rdata = 0;
    bram_ready = 0; uart_ready = 0; timer_ready = 0;
    #2 rst = 1'b0;
    #1;
    chk("rst_m_ready", {30'd0, m0_ready, m1_ready}, 32'd0);
    chk("rst_m_error", {30'd0, m0_error, m1_error}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_svalid", {29'd0, bram_valid, uart_valid, timer_valid}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    cyc(); cyc();
    rst = 1'b1;

    // Tie after reset: m0 (uart write) first, then m1 (bram read)
    m0_valid = 1; m0_addr = 32'h1000_0000; m0_wstrb = 4'h1; m0_wdata = 32'h55;
    m1_valid = 1; m1_addr = 32'h200;
    cyc();
    chk("tie_uart_valid", {31'd0, uart_valid}, 32'd1);
    chk("tie_bram_idle", {31'd0, bram_valid}, 32'd0);
    chk("tie_s_addr", s_addr, 32'h1000_0000);
    chk("tie_s_wstrb", {28'd0, s_wstrb}, 32'h1);
    chk("tie_s_wdata", s_wdata, 32'h55);
    cyc();
    chk("tie_uart_pulse", {31'd0, uart_valid}, 32'd0);
    uart_ready = 1; uart_rdata = 32'h11;
    cyc();
    uart_ready = 0;
    chk("tie_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("tie_m0_rdata", m0_rdata, 32'h11);
    chk("tie_m1_quiet", {31'd0, m1_ready}, 32'd0);
    m0_valid = 0; m0_wstrb = 0;
    cyc();
    cyc();
    chk("tie_m1_bram", {31'd0, bram_valid}, 32'd1);
    chk("tie_m1_addr", s_addr, 32'h200);
    cyc();
    bram_ready = 1; bram_rdata = 32'h22;
    cyc();
    bram_ready = 0;
    chk("tie_m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("tie_m1_rdata", m1_rdata, 32'h22);
    chk("tie_m0_rdata0", m0_rdata, 32'd0);
    m1_addr = 32'h400; m0_valid = 1; m0_addr = 32'h300;
    cyc();
    cyc();
    chk("rr2_m0_addr", s_addr, 32'h300);
    cyc();
    bram_ready = 1; bram_rdata = 32'h33;
    cyc();
    bram_ready = 0;
    chk("rr2_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("rr2_m0_rdata", m0_rdata, 32'h33);
    m0_valid = 0;
    cyc();
    cyc();
    chk("rr2_m1_addr", s_addr, 32'h400);
    cyc();
    bram_ready = 1; bram_rdata = 32'h44;
    cyc();
    bram_ready = 0;
    chk("rr2_m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("rr2_m1_rdata", m1_rdata, 32'h44);
    m1_valid = 0;
    cyc();

    // Single m0 bram read, k=1
    m0_valid = 1; m0_addr = 32'h100;
    cyc();
    chk("rd_valids", {29'd0, bram_valid, uart_valid, timer_valid}, 32'b100);
    cyc();
    chk("rd_bram_pulse", {31'd0, bram_valid}, 32'd0);
    chk("rd_no_early", {31'd0, m0_ready}, 32'd0);
    bram_ready = 1; bram_rdata = 32'hDEAD_BEEF;
    cyc();
    bram_ready = 0;
    chk("rd_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_m0_error", {31'd0, m0_error}, 32'd0);
    chk("rd_m1_quiet", {30'd0, m1_ready, m1_error}, 32'd0);
    chk("rd_m1_rdata", m1_rdata, 32'd0);
    m0_valid = 0;
    cyc();

    // m1 timer read with a stray bram_ready while waiting
    m1_valid = 1; m1_addr = 32'h0200_BFF8; m1_instr = 1;
    cyc();
    chk("tmr_valids", {29'd0, bram_valid, uart_valid, timer_valid}, 32'b001);
    chk("tmr_s_addr", s_addr, 32'h0200_BFF8);
    chk("tmr_s_instr", {31'd0, s_instr}, 32'd1);
    cyc();
    bram_ready = 1; bram_rdata = 32'hBAD0_BAD0;
    cyc();
    chk("tmr_stray_ign", {31'd0, m1_ready}, 32'd0);
    bram_ready = 0; timer_ready = 1; timer_rdata = 32'h1234_5678;
    cyc();
    timer_ready = 0;
    chk("tmr_m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("tmr_m1_rdata", m1_rdata, 32'h1234_5678);
    chk("tmr_m1_error", {31'd0, m1_error}, 32'd0);
    m1_valid = 0; m1_instr = 0;
    cyc();

    // Timeout with TIMEOUT=8: response 9 cycles after REQ
    m0_valid = 1; m0_addr = 32'h100;
    cyc();
    chk("to_req", {31'd0, bram_valid}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk($sformatf("to_wait%0d", i), {31'd0, m0_ready}, 32'd0);
    end
    cyc();
    chk("to_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("to_m0_error", {31'd0, m0_error}, 32'd1);
    chk("to_m0_rdata", m0_rdata, 32'd0);
    m0_valid = 0;
    cyc();

    // Late bram_ready in IDLE and during an m1 uart transaction
    bram_ready = 1; bram_rdata = 32'h0BAD_0BAD;
    m1_valid = 1; m1_addr = 32'h1000_0000;
    cyc();
    bram_ready = 0;
    chk("late_uart_valid", {31'd0, uart_valid}, 32'd1);
    cyc();
    bram_ready = 1;
    cyc();
    chk("late_ignored", {31'd0, m1_ready}, 32'd0);
    bram_ready = 0; uart_ready = 1; uart_rdata = 32'hCAFE;
    cyc();
    uart_ready = 0;
    chk("late_m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("late_m1_rdata", m1_rdata, 32'hCAFE);
    chk("late_m1_error", {31'd0, m1_error}, 32'd0);
    m1_valid = 0;
    cyc();

    // Unmapped read
    m0_valid = 1; m0_addr = 32'h8000_0000;
    cyc();
    chk("um_no_valid", {29'd0, bram_valid, uart_valid, timer_valid}, 32'd0);
    chk("um_no_ready", {31'd0, m0_ready}, 32'd0);
    cyc();
    chk("um_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("um_m0_error", {31'd0, m0_error}, 32'd1);
    chk("um_m0_rdata", m0_rdata, 32'd0);
    m0_valid = 0;
    cyc();

    // Reset during WAIT
    m0_valid = 1; m0_addr = 32'h100;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("mrst_s_addr", s_addr, 32'd0);
    chk("mrst_ready", {30'd0, m0_ready, m1_ready}, 32'd0);
    m0_valid = 0;
    cyc();
    chk("mrst_hold", {31'd0, m0_ready}, 32'd0);
    rst = 1'b1;
    m0_valid = 1; m0_addr = 32'h200;
    m1_valid = 1; m1_addr = 32'h1000_0000;
    cyc();
    chk("mrst_tie_m0", s_addr, 32'h200);
    chk("mrst_tie_bram", {31'd0, bram_valid}, 32'd1);
    cyc();
    bram_ready = 1; bram_rdata = 32'h77;
    cyc();
    bram_ready = 0;
    chk("mrst_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("mrst_m0_rdata", m0_rdata, 32'h77);
    m0_valid = 0; m1_valid = 0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
